sseg_scan_driver: RTL and testbench

// Time-multiplexed 7-segment display driver. Shows N_DIGITS hex nibbles on a

---
 rtl/sseg_scan_driver.sv | 189 ++++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous double-buffered value.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [6:0]              segments,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_start,
    output logic [4*N_DIGITS-1:0]   shown_value
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DRIVE_END = CW'(REFRESH_DIV - GAP_CYCLES);
    localparam logic [CW-1:0] BOOT_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    typedef enum logic {
        ST_GAP,
        ST_DRIVE
    } state_t;

    state_t                   state_reg, state_next;
    logic [CW-1:0]            cnt_reg, cnt_next;
    logic [IW-1:0]            idx_reg, idx_next;
    logic                     boot_reg, boot_next;
    logic [4*N_DIGITS-1:0]    pending_reg, pending_next;
    logic                     pending_valid_reg, pending_valid_next;
    logic [4*N_DIGITS-1:0]    shown_reg, shown_next;
    logic [6:0]               segments_reg, segments_next;
    logic [N_DIGITS-1:0]      anodes_reg, anodes_next;
    logic                     frame_start_reg, frame_start_next;
    logic                     slot_start;
    logic                     frame_edge;
    logic                     blank;
    logic [3:0]               nib_next [N_DIGITS];

    function automatic logic [6:0] enc(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
            assign nib_next[gi] = shown_next[4*gi +: 4];
        end
    endgenerate

    // Slot timing: after reset a shortened boot slot of pure gap precedes digit 0.
    always_comb begin
        cnt_next   = cnt_reg + CW'(1);
        boot_next  = boot_reg;
        idx_next   = idx_reg;
        slot_start = 1'b0;
        if (boot_reg) begin
            if (cnt_reg == BOOT_LAST) begin
                cnt_next   = '0;
                boot_next  = 1'b0;
                slot_start = 1'b1;
            end
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            slot_start = 1'b1;
        end
        if (slot_start) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
        state_next = (!boot_next && cnt_next < DRIVE_END) ? ST_DRIVE : ST_GAP;
        frame_edge = slot_start && (idx_next == '0);
    end

    always_comb begin
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        shown_next         = shown_reg;
        if (frame_edge) begin
            if (load) begin
                shown_next = value;
            end else if (pending_valid_reg) begin
                shown_next = pending_reg;
            end
            pending_valid_next = 1'b0;
        end else if (load) begin
            pending_next       = value;
            pending_valid_next = 1'b1;
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    logic [N_DIGITS-1:0] nz_next;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nz
            assign nz_next[gi] = |nib_next[gi];
        end
    endgenerate

    // Blank when no nonzero nibble sits at or above this digit; digit 0 always shows.
    always_comb begin
        logic higher_nz;
        higher_nz = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx_next)) begin
                higher_nz = higher_nz | nz_next[i];
            end
        end
        blank = (idx_next != '0) && !higher_nz;
    end
`else
    assign blank = 1'b0;
`endif

    // Slot contents are fixed at slot start and held for the rest of DRIVE.
    always_comb begin
        anodes_next      = '1;
        segments_next    = 7'h7F;
        frame_start_next = frame_edge;
        if (state_next == ST_DRIVE) begin
            if (slot_start) begin
                if (!blank) begin
                    segments_next = enc(nib_next[idx_next]);
                    if (digit_en[idx_next]) begin
                        anodes_next[idx_next] = 1'b0;
                    end
                end
            end else if (state_reg == ST_DRIVE) begin
                anodes_next   = anodes_reg;
                segments_next = segments_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_GAP;
            cnt_reg           <= '0;
            idx_reg           <= IDX_LAST;
            boot_reg          <= 1'b1;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            shown_reg         <= '0;
            segments_reg      <= 7'h7F;
            anodes_reg        <= '1;
            frame_start_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            idx_reg           <= idx_next;
            boot_reg          <= boot_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            shown_reg         <= shown_next;
            segments_reg      <= segments_next;
            anodes_reg        <= anodes_next;
            frame_start_reg   <= frame_start_next;
        end
    end

    assign segments    = segments_reg;
    assign anodes      = anodes_reg;
    assign frame_start = frame_start_reg;
    assign shown_value = shown_reg;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: a timeline model pushes per-cycle expectations,
// a negedge monitor pops and compares. Honours SSEG_LZ_BLANK_EN like the design.
module tb_sseg_scan_driver;

    localparam int N  = 8;
    localparam int R  = 8;
    localparam int G  = 2;
    localparam int FR = N * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic [7:0]  digit_en = 8'hFF;
    logic [6:0]  segments;
    logic [7:0]  anodes;
    logic        frame_start;
    logic [31:0] shown_value;

    sseg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .digit_en(digit_en),
        .segments(segments), .anodes(anodes), .frame_start(frame_start),
        .shown_value(shown_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        fs;
        logic [31:0] sv;
        int          k;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Model state, written only by the model process.
    int          k = 0;
    int          cur_digit = 0;
    logic        cur_drive = 1'b0;
    logic [31:0] m_shown = '0;
    logic [31:0] m_pend = '0;
    logic        m_valid = 1'b0;
    logic [7:0]  en_slot = 8'hFF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp, input int kk);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%h expected=%h", name, kk, got, exp);
        end
    endtask

    // Reference model: position on the frame timeline after reset release.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            if (!rst_n) begin
                k = 0;
                m_shown = '0; m_pend = '0; m_valid = 1'b0;
                cur_drive = 1'b0;
                e = '{an: 8'hFF, seg: 7'h7F, fs: 1'b0, sv: 32'h0, k: 0};
            end else begin
                int p, phase;
                logic bnd, blank;
                logic [3:0] nib;
                k++;
                p = k - G;
                bnd = (p >= 0) && (p % FR == 0);
                if (bnd) begin
                    m_shown = load ? value : (m_valid ? m_pend : m_shown);
                    m_valid = 1'b0;
                end else if (load) begin
                    m_pend = value;
                    m_valid = 1'b1;
                end
                e = '{an: 8'hFF, seg: 7'h7F, fs: bnd, sv: m_shown, k: k};
                cur_drive = 1'b0;
                if (p >= 0) begin
                    phase = p % R;
                    cur_digit = (p / R) % N;
                    if (phase == 0) en_slot = digit_en;
                    if (phase < R - G) begin
                        cur_drive = 1'b1;
                        nib = 4'(m_shown >> (4 * cur_digit));
                        blank = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
                        blank = (cur_digit != 0) && ((m_shown >> (4 * cur_digit)) == 32'h0);
`endif
                        if (!blank) begin
                            e.seg = seg_tbl[nib];
                            if (en_slot[cur_digit]) e.an[cur_digit] = 1'b0;
                        end
                    end
                end
            end
            q.push_back(e);
        end
    end

    // Monitor: one expectation per cycle, compared away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("anodes", 32'(anodes), 32'(e.an), e.k);
                check("segments", 32'(segments), 32'(e.seg), e.k);
                check("frame_start", 32'(frame_start), 32'(e.fs), e.k);
                check("shown_value", shown_value, e.sv, e.k);
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        $display("[TB] load %h at k=%0d", v, k);
    endtask

    // Wait until the next posedge is a frame boundary.
    task automatic wait_boundary();
        int n;
        n = 0;
        while (!((k + 1 - G) >= 0 && ((k + 1 - G) % FR) == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL wait_boundary timed out k=%0d", k);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        $display("[TB] test1: reset release, no load");
        cycles(70);

        $display("[TB] test2: mid-frame load");
        cycles(20);
        do_load(32'h89AB_CDEF);
        cycles(2 * FR);

        $display("[TB] test3: overwrite and boundary bypass");
        wait_boundary();
        cycles(6);
        do_load(32'h1111_1111);
        cycles(10);
        do_load(32'h2222_2222);
        cycles(FR);
        wait_boundary();
        do_load(32'h3456_789A);
        cycles(FR);

        $display("[TB] test4: digit_en=0F");
        digit_en = 8'h0F;
        cycles(2 * FR + 5);
        digit_en = 8'hFF;

        $display("[TB] test5: async reset during digit 3");
        begin
            int n;
            n = 0;
            while (!(cur_drive && cur_digit == 3) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                n_tests++; n_fail++;
                $display("FAIL wait_digit3 timed out k=%0d", k);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_anodes", 32'(anodes), 32'hFF, k);
        check("async_segments", 32'(segments), 32'h7F, k);
        check("async_shown", shown_value, 32'h0, k);
        @(negedge clk);
        value = 32'hDEAD_BEEF;
        load  = 1'b1;
        cycles(2);
        load  = 1'b0;
        rst_n = 1'b1;
        cycles(FR + 10);

        $display("[TB] test6: value 000000A0");
        do_load(32'h0000_00A0);
        cycles(2 * FR);

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                value = $urandom >> (4 * $urandom_range(0, 7));
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) digit_en = 8'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        cycles(3);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
